mem_stage: RTL and testbench

Memory-access stage of the five-stage MIPS pipeline, directly downstream of the execute stage and upstream of write-back. It latches the execute-stage bus and waits for the data-SRAM `data_ok` response for any request the execute stage got accepted. It then aligns and extends load data (including LWL/LWR byte-strobe merging) and forwards exception and CP0 information. A one-entry response buffer absorbs `data_ok` when write-back stalls. A discard counter drops responses that belong to flushed instructions.

---
 rtl/mem_stage.sv | 159 +++++++++++++++
 tb/tb_mem_stage.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, aligns and extends load data,
// and forwards exception/CP0 state to write-back. It also drops responses owed to flushed instructions.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 166,
  parameter int MS_TO_WS_BUS_WD = 155,
  parameter int MS_RES_WD       = 42
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  input  logic [6:0]                 wbexc,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [6:0]                 memexc,
  output logic [MS_RES_WD-1:0]       ms_res
);

  logic                       ms_valid_q, ms_valid_d;
  logic [ES_TO_MS_BUS_WD-1:0] es_bus_q, es_bus_d;
  logic                       rbuf_valid_q, rbuf_valid_d;
  logic [31:0]                rbuf_data_q, rbuf_data_d;
  logic [1:0]                 discard_cnt_q, discard_cnt_d;

  logic        mem_req_sent_s, at_delay_slot_s, res_from_mem_s;
  logic [41:0] cp0_msg_s;
  logic [6:0]  exception_s, memop_s;
  logic [1:0]  k_s;
  logic [31:0] badvaddr_s, alu_result_s, pc_s;
  logic [3:0]  gr_we_s;
  logic [4:0]  dest_s;

  assign mem_req_sent_s  = es_bus_q[165];
  assign at_delay_slot_s = es_bus_q[164];
  assign cp0_msg_s       = es_bus_q[163:122];
  assign exception_s     = es_bus_q[121:115];
  assign k_s             = es_bus_q[114:113];
  assign memop_s         = es_bus_q[112:106];
  assign badvaddr_s      = es_bus_q[105:74];
  assign res_from_mem_s  = es_bus_q[73];
  assign gr_we_s         = es_bus_q[72:69];
  assign dest_s          = es_bus_q[68:64];
  assign alu_result_s    = es_bus_q[63:32];
  assign pc_s            = es_bus_q[31:0];

  logic flush_s, data_ok_s, ready_go_s, handoff_s, owed_s, inc_s, dec_s;

  // A data_ok only counts for this stage once all responses owed to flushed instructions are gone.
  assign flush_s    = |wbexc;
  assign data_ok_s  = data_sram_data_ok & (discard_cnt_q == 2'd0);
  assign ready_go_s = ~mem_req_sent_s | rbuf_valid_q | data_ok_s;
  assign handoff_s  = ms_valid_q & ready_go_s & ws_allowin;
  assign owed_s     = ms_valid_q & mem_req_sent_s & ~rbuf_valid_q & ~data_ok_s;
  assign inc_s      = flush_s & owed_s;
  assign dec_s      = data_sram_data_ok & (discard_cnt_q != 2'd0);

  assign ms_allowin     = ~ms_valid_q | (ready_go_s & ws_allowin);
  assign ms_to_ws_valid = ms_valid_q & ready_go_s;

  logic [31:0] ld_data_s, shr_s, final_result_s;
  logic [15:0] half_s;
  logic [3:0]  strobe_s, gr_we_out_s;

  // Load alignment, extension and partial-word strobes.
  always_comb begin
    ld_data_s = rbuf_valid_q ? rbuf_data_q : data_sram_rdata;
    shr_s     = ld_data_s >> {k_s, 3'b000};
    half_s    = k_s[1] ? ld_data_s[31:16] : ld_data_s[15:0];
    strobe_s  = 4'hF;
    final_result_s = alu_result_s;
    if (res_from_mem_s) begin
      if (memop_s[1]) begin
        final_result_s = {{24{shr_s[7]}}, shr_s[7:0]};
      end else if (memop_s[2]) begin
        final_result_s = {24'h000000, shr_s[7:0]};
      end else if (memop_s[3]) begin
        final_result_s = {{16{half_s[15]}}, half_s};
      end else if (memop_s[4]) begin
        final_result_s = {16'h0000, half_s};
      end else if (memop_s[5]) begin
        final_result_s = ld_data_s << {~k_s, 3'b000};
        strobe_s       = 4'hF << ~k_s;
      end else if (memop_s[6]) begin
        final_result_s = shr_s;
        strobe_s       = 4'hF >> k_s;
      end else begin
        final_result_s = ld_data_s;
      end
    end else begin
      final_result_s = alu_result_s;
    end
    gr_we_out_s = gr_we_s & strobe_s;
  end

  assign ms_to_ws_bus = {at_delay_slot_s, cp0_msg_s, exception_s, badvaddr_s,
                         gr_we_out_s, dest_s, final_result_s, pc_s};
  assign memexc = ms_valid_q ? exception_s : 7'h00;
  assign ms_res = {ms_valid_q & res_from_mem_s & ~ready_go_s,
                   gr_we_out_s & {4{ms_valid_q}}, dest_s, final_result_s};

  // Next-state for the stage contents, the response buffer and the discard counter.
  always_comb begin
    ms_valid_d    = ms_valid_q;
    es_bus_d      = es_bus_q;
    rbuf_valid_d  = rbuf_valid_q;
    rbuf_data_d   = rbuf_data_q;
    discard_cnt_d = discard_cnt_q;
    if (flush_s) begin
      ms_valid_d   = 1'b0;
      rbuf_valid_d = 1'b0;
    end else begin
      if (ms_allowin) begin
        ms_valid_d = es_to_ms_valid;
        if (es_to_ms_valid) begin
          es_bus_d = es_to_ms_bus;
        end else begin
          es_bus_d = es_bus_q;
        end
      end else begin
        ms_valid_d = ms_valid_q;
      end
      if (handoff_s) begin
        rbuf_valid_d = 1'b0;
      end else if (ms_valid_q & mem_req_sent_s & ~rbuf_valid_q & data_ok_s) begin
        rbuf_valid_d = 1'b1;
        rbuf_data_d  = data_sram_rdata;
      end else begin
        rbuf_valid_d = rbuf_valid_q;
      end
    end
    case ({inc_s, dec_s})
      2'b10:   discard_cnt_d = (discard_cnt_q == 2'd3) ? 2'd3 : discard_cnt_q + 2'd1;
      2'b01:   discard_cnt_d = discard_cnt_q - 2'd1;
      default: discard_cnt_d = discard_cnt_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_q    <= 1'b0;
      es_bus_q      <= '0;
      rbuf_valid_q  <= 1'b0;
      rbuf_data_q   <= 32'h0000_0000;
      discard_cnt_q <= 2'd0;
    end else begin
      ms_valid_q    <= ms_valid_d;
      es_bus_q      <= es_bus_d;
      rbuf_valid_q  <= rbuf_valid_d;
      rbuf_data_q   <= rbuf_data_d;
      discard_cnt_q <= discard_cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-load/store vectors plus hand-written
// sequences for response buffering, flush/discard and asynchronous reset.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [165:0] es_to_ms_bus;
  logic [6:0]   wbexc;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ms_to_ws_valid;
  logic [154:0] ms_to_ws_bus;
  logic [6:0]   memexc;
  logic [41:0]  ms_res;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
    .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus), .wbexc(wbexc),
    .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .memexc(memexc), .ms_res(ms_res)
  );

  typedef struct {
    logic        memreq;
    logic [6:0]  memop;
    logic [1:0]  k;
    logic        rfm;
    logic [3:0]  gr_we;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [6:0]  exc;
    logic [31:0] exp_res;
    logic [3:0]  exp_we;
  } vec_t;

  localparam logic [6:0] LW = 7'h01, LB = 7'h02, LBU = 7'h04, LH = 7'h08,
                         LHU = 7'h10, LWL = 7'h20, LWR = 7'h40, NOP = 7'h00;

  function automatic logic [165:0] mk_bus(input logic memreq, input logic [6:0] exc,
      input logic [1:0] k, input logic [6:0] memop, input logic rfm, input logic [3:0] we,
      input logic [4:0] dest, input logic [31:0] alu, input logic [31:0] pc);
    return {memreq, 1'b0, 42'h0, exc, k, memop, alu, rfm, we, dest, alu, pc};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{1'b1, LB,  2'd3, 1'b1, 4'hF, 32'h80FF_1234, 32'h5555_0000, 7'h00, 32'hFFFF_FF80, 4'hF};
    tbl[1]  = '{1'b1, LBU, 2'd3, 1'b1, 4'hF, 32'h80FF_1234, 32'h5555_0000, 7'h00, 32'h0000_0080, 4'hF};
    tbl[2]  = '{1'b1, LWL, 2'd1, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h5555_0000, 7'h00, 32'hCCDD_0000, 4'hC};
    tbl[3]  = '{1'b1, LWR, 2'd1, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h5555_0000, 7'h00, 32'h00AA_BBCC, 4'h7};
    tbl[4]  = '{1'b1, LH,  2'd2, 1'b1, 4'hF, 32'h8001_7FFF, 32'h5555_0000, 7'h00, 32'hFFFF_8001, 4'hF};
    tbl[5]  = '{1'b1, LHU, 2'd2, 1'b1, 4'hF, 32'h8001_7FFF, 32'h5555_0000, 7'h00, 32'h0000_8001, 4'hF};
    tbl[6]  = '{1'b1, LH,  2'd0, 1'b1, 4'hF, 32'h8001_7FFF, 32'h5555_0000, 7'h00, 32'h0000_7FFF, 4'hF};
    tbl[7]  = '{1'b1, LW,  2'd0, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h5555_0000, 7'h00, 32'hDEAD_BEEF, 4'hF};
    tbl[8]  = '{1'b1, LB,  2'd0, 1'b1, 4'hF, 32'h80FF_1234, 32'h5555_0000, 7'h00, 32'h0000_0034, 4'hF};
    tbl[9]  = '{1'b1, LB,  2'd2, 1'b1, 4'hF, 32'h80FF_1234, 32'h5555_0000, 7'h00, 32'hFFFF_FFFF, 4'hF};
    tbl[10] = '{1'b1, LWL, 2'd3, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h5555_0000, 7'h00, 32'hAABB_CCDD, 4'hF};
    tbl[11] = '{1'b1, LWL, 2'd0, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h5555_0000, 7'h00, 32'hDD00_0000, 4'h8};
    tbl[12] = '{1'b1, LWR, 2'd3, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h5555_0000, 7'h00, 32'h0000_00AA, 4'h1};
    tbl[13] = '{1'b1, LWR, 2'd0, 1'b1, 4'hF, 32'hAABB_CCDD, 32'h5555_0000, 7'h00, 32'hAABB_CCDD, 4'hF};
    tbl[14] = '{1'b0, NOP, 2'd0, 1'b0, 4'hF, 32'h0000_0000, 32'h1111_2222, 7'h08, 32'h1111_2222, 4'hF};
    tbl[15] = '{1'b1, NOP, 2'd0, 1'b0, 4'h0, 32'hFFFF_FFFF, 32'h0000_1000, 7'h00, 32'h0000_1000, 4'h0};

    ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; wbexc = 7'h00;
    data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;

    // reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("rst_memexc", 32'(memexc), 32'd0);
    chk("rst_msres", 32'(ms_res[41:32]) | ms_res[31:0], 32'd0);
    chk("rst_allowin", 32'(ms_allowin), 32'd1);
    @(negedge clk);
    reset = 1'b0;

    // table-driven single instructions
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      es_to_ms_valid = 1'b1;
      es_to_ms_bus = mk_bus(tbl[i].memreq, tbl[i].exc, tbl[i].k, tbl[i].memop, tbl[i].rfm,
                            tbl[i].gr_we, 5'(i + 1), tbl[i].alu, 32'hBFC0_0000 + 32'(i * 4));
      @(negedge clk);
      es_to_ms_valid = 1'b0;
      es_to_ms_bus = '0;
      if (tbl[i].memreq) begin
        #1;
        chk($sformatf("v%0d_wait_valid", i), 32'(ms_to_ws_valid), 32'd0);
        chk($sformatf("v%0d_wait_pend", i), 32'(ms_res[41]), 32'(tbl[i].rfm));
        @(negedge clk);
        data_sram_data_ok = 1'b1;
        data_sram_rdata = tbl[i].rdata;
      end
      #1;
      chk($sformatf("v%0d_valid", i), 32'(ms_to_ws_valid), 32'd1);
      chk($sformatf("v%0d_result", i), ms_to_ws_bus[63:32], tbl[i].exp_res);
      chk($sformatf("v%0d_we", i), 32'(ms_to_ws_bus[72:69]), 32'(tbl[i].exp_we));
      chk($sformatf("v%0d_pc", i), ms_to_ws_bus[31:0], 32'hBFC0_0000 + 32'(i * 4));
      chk($sformatf("v%0d_memexc", i), 32'(memexc), 32'(tbl[i].exc));
      chk($sformatf("v%0d_busexc", i), 32'(ms_to_ws_bus[111:105]), 32'(tbl[i].exc));
      chk($sformatf("v%0d_fwd", i), ms_res[31:0], tbl[i].exp_res);
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'h0;
      #1;
      chk($sformatf("v%0d_after", i), 32'(ms_to_ws_valid), 32'd0);
    end

    // response buffer: data_ok while write-back stalls for 3 cycles
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 7'h00, 2'd0, LW, 1'b1, 4'hF, 5'd9, 32'h0, 32'h0000_1000);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h1234_5678;
    #1;
    chk("rb_allowin0", 32'(ms_allowin), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      data_sram_data_ok = 1'b0;
      data_sram_rdata = 32'hFFFF_FFFF;
      #1;
      chk("rb_held", ms_to_ws_bus[63:32], 32'h1234_5678);
      chk("rb_stall", 32'(ms_allowin), 32'd0);
    end
    @(negedge clk);
    ws_allowin = 1'b1;
    #1;
    chk("rb_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("rb_result", ms_to_ws_bus[63:32], 32'h1234_5678);
    chk("rb_allowin1", 32'(ms_allowin), 32'd1);
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 7'h00, 2'd0, LW, 1'b1, 4'hF, 5'd10, 32'h0, 32'h0000_1004);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    #1;
    chk("rb_cleared", 32'(ms_to_ws_valid), 32'd0);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'hCAFE_0001;
    #1;
    chk("rb_next", ms_to_ws_bus[63:32], 32'hCAFE_0001);
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // flush while a response is owed, then discard it
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 7'h00, 2'd0, LW, 1'b1, 4'hF, 5'd11, 32'h0, 32'h0000_2000);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    wbexc = 7'h01;
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b0, 7'h02, 2'd0, NOP, 1'b0, 4'hF, 5'd12, 32'h1, 32'h0000_2004);
    #1;
    chk("dc_flushed", 32'(ms_to_ws_valid), 32'd0);
    chk("dc_cnt1", 32'(dut.discard_cnt_q), 32'd1);
    @(negedge clk);
    wbexc = 7'h00;
    es_to_ms_valid = 1'b0;
    #1;
    chk("dc_dropped", 32'(ms_to_ws_valid), 32'd0);
    chk("dc_memexc", 32'(memexc), 32'd0);
    chk("dc_cnt_keep", 32'(dut.discard_cnt_q), 32'd1);
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 7'h00, 2'd0, LW, 1'b1, 4'hF, 5'd13, 32'h0, 32'h0000_2008);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h0BAD_0BAD;
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    data_sram_data_ok = 1'b0;
    #1;
    chk("dc_cnt0", 32'(dut.discard_cnt_q), 32'd0);
    chk("dc_wait", 32'(ms_to_ws_valid), 32'd0);
    chk("dc_pend", 32'(ms_res[41]), 32'd1);
    @(negedge clk);
    data_sram_data_ok = 1'b1;
    data_sram_rdata = 32'h600D_600D;
    #1;
    chk("dc_valid", 32'(ms_to_ws_valid), 32'd1);
    chk("dc_result", ms_to_ws_bus[63:32], 32'h600D_600D);
    chk("dc_pc", ms_to_ws_bus[31:0], 32'h0000_2008);
    @(negedge clk);
    data_sram_data_ok = 1'b0;

    // asynchronous reset while a load waits and a discard is pending
    @(negedge clk);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 7'h00, 2'd0, LW, 1'b1, 4'hF, 5'd14, 32'h0, 32'h0000_3000);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    wbexc = 7'h01;
    @(negedge clk);
    wbexc = 7'h00;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus = mk_bus(1'b1, 7'h04, 2'd0, LW, 1'b1, 4'hF, 5'd15, 32'h0, 32'h0000_3004);
    @(negedge clk);
    es_to_ms_valid = 1'b0;
    ws_allowin = 1'b0;
    #1;
    chk("ar_memexc_pre", 32'(memexc), 32'h04);
    chk("ar_cnt_pre", 32'(dut.discard_cnt_q), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(ms_to_ws_valid), 32'd0);
    chk("ar_memexc", 32'(memexc), 32'd0);
    chk("ar_msres", 32'(ms_res[41:32]) | ms_res[31:0], 32'd0);
    chk("ar_bus", ms_to_ws_bus[154:123] | ms_to_ws_bus[122:91] | ms_to_ws_bus[90:59]
                  | ms_to_ws_bus[58:27] | 32'(ms_to_ws_bus[26:0]), 32'd0);
    chk("ar_cnt", 32'(dut.discard_cnt_q), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    ws_allowin = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
